// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer bus master fed from a small command FIFO.
// One NONSEQ word transfer per command, registered response, data-phase wait watchdog.
module ahb_lite_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk100m,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH     = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    // Each entry is {write, addr[31:0], wdata[31:0]}.
    logic [64:0]   mem [FIFO_DEPTH];
    logic [64:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [7:0]    wait_cnt;
    logic [31:0]   cur_wdata;

    assign empty     = (count == '0);
    assign cmd_ready = (count != DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && !empty && hready;
    assign head      = mem[rd_ptr];
    assign busy      = !empty || (state != S_IDLE);
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;

    // NOTE: the storage array has no reset; pointers and count are reset, so a stale entry is never popped.
    always_ff @(posedge clk100m) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments throughout, so every register here sees pre-edge values of the others.
    always_ff @(posedge clk100m or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            htrans      <= TRANS_IDLE;
            haddr       <= '0;
            hwrite      <= 1'b0;
            hwdata      <= '0;
            cur_wdata   <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        hwrite    <= head[64];
                        haddr     <= head[63:32];
                        cur_wdata <= head[31:0];
                        htrans    <= TRANS_NONSEQ;
                        state     <= S_ADDR;
                    end else begin
                        htrans <= TRANS_IDLE;
                    end
                end
                S_ADDR: begin
                    if (hready) begin
                        htrans   <= TRANS_IDLE;
                        hwdata   <= cur_wdata;
                        wait_cnt <= '0;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (hready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= (hwrite || hresp) ? '0 : hrdata;
                        rsp_err     <= hresp;
                        rsp_timeout <= 1'b0;
                        state       <= S_IDLE;
                    end else if (hresp) begin
                        state <= S_ERR2;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // Give up on the slave; IDLE will not issue again until it raises hready.
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ERR2: begin
                    if (hready) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Self-checking bench for ahb_lite_cmd_master: behavioural AHB slave, transaction-level
// reference model with a response scoreboard, directed vector table and random traffic.
`timescale 1ns/1ps
module tb_ahb_lite_cmd_master;

    localparam int TMO   = 8;
    localparam int STALL = 1000;

    logic        clk100m = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp  = 1'b0;

    ahb_lite_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .clk100m(clk100m), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    always #5 clk100m = ~clk100m;

    int cyc = 0;
    always @(posedge clk100m) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic [31:0] rdata; logic err; logic tmo; } rsp_t;
    typedef struct { logic w; logic [31:0] a; logic [31:0] d; int waits; } bus_t;
    typedef struct {
        logic w; logic [31:0] a; logic [31:0] d; int waits;
        logic [31:0] rdata; logic err; logic tmo; int lat;
    } vec_t;

    rsp_t        exp_q[$];
    bus_t        bus_q[$];
    int          acc_cyc[$];
    logic [31:0] model_mem [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    // Contents of a never-written word, as the slave reports it.
    function automatic logic [31:0] fresh(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic is_err_addr(input logic [31:0] a);
        return a[15:12] == 4'hE;
    endfunction

    // Reference model: each accepted command resolves in order, by these rules alone.
    int push_cyc = 0;
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits);
        rsp_t e;
        bus_t b;
        int   n = 0;
        @(negedge clk100m);
        while (!cmd_ready && n < 200) begin
            @(negedge clk100m);
            n++;
        end
        if (!cmd_ready) begin
            check("push_ready", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        @(posedge clk100m);
        #1;
        push_cyc  = cyc;
        cmd_valid = 1'b0;
        b = '{w, a, d, waits};
        bus_q.push_back(b);
        if (waits >= TMO)          e = '{32'h0, 1'b0, 1'b1};
        else if (is_err_addr(a))   e = '{32'h0, 1'b1, 1'b0};
        else if (w) begin
            model_mem[a] = d;
            e = '{32'h0, 1'b0, 1'b0};
        end else                   e = '{model_mem.exists(a) ? model_mem[a] : fresh(a), 1'b0, 1'b0};
        exp_q.push_back(e);
    endtask

    // Behavioural slave: drives hready/hresp/hrdata mid-cycle for the edge that follows.
    logic dp_act = 1'b0;
    bus_t dp;
    int   dp_wait = 0;
    logic err_sent = 1'b0;
    logic sl_done;
    logic idle_hold = 1'b0;
    logic release_stall = 1'b0;

    always @(negedge clk100m) begin
        sl_done = 1'b0;
        if (!rst_n) begin
            dp_act = 1'b0; hready = 1'b1; hresp = 1'b0;
        end else begin
            if (release_stall) begin
                dp_act = 1'b0; release_stall = 1'b0;
            end
            if (dp_act) begin
                if (dp_wait > 0) begin
                    hready = 1'b0; hresp = 1'b0; hrdata = $urandom(); dp_wait--;
                end else if (is_err_addr(dp.a) && !err_sent) begin
                    hready = 1'b0; hresp = 1'b1; err_sent = 1'b1;
                end else begin
                    hready = 1'b1; hresp = is_err_addr(dp.a); sl_done = 1'b1;
                    hrdata = $urandom();
                    if (!hresp && dp.waits < TMO) begin
                        if (dp.w) begin
                            check("hwdata", hwdata, dp.d);
                            slave_mem[dp.a] = hwdata;
                        end else begin
                            hrdata = slave_mem.exists(dp.a) ? slave_mem[dp.a] : fresh(dp.a);
                        end
                    end
                end
            end else begin
                hready = !idle_hold; hresp = 1'b0;
            end
            if (sl_done) dp_act = 1'b0;
            if (hready && htrans == 2'b10) begin
                acc_cyc.push_back(cyc);
                if (bus_q.size() == 0) begin
                    check("nonseq_unexpected", 32'(htrans), 32'd0);
                end else begin
                    dp = bus_q.pop_front();
                    check("haddr", haddr, dp.a);
                    check("hwrite", 32'(hwrite), 32'(dp.w));
                    dp_act = 1'b1; dp_wait = dp.waits; err_sent = 1'b0;
                end
            end
        end
    end

    // Response scoreboard.
    int          rsp_cnt = 0;
    int          last_rsp_cyc = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        last_tmo = 1'b0;
    logic        prev_rsp = 1'b0;
    rsp_t        mon_e;

    always @(negedge clk100m) begin
        if (rst_n && rsp_valid) begin
            check("rsp_pulse", 32'(prev_rsp), 32'd0);
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.tmo));
            end
            last_rsp_cyc = cyc; last_rdata = rsp_rdata;
            last_err = rsp_err; last_tmo = rsp_timeout;
            rsp_cnt++;
        end
        prev_rsp = rsp_valid;
    end

    task automatic wait_rsp(input int target, input string name);
        int n = 0;
        while (rsp_cnt < target && n < 400) begin
            @(posedge clk100m);
            n++;
        end
        #1;
        check(name, 32'(rsp_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    vec_t vec [9];
    int   base;

    initial begin
        vec[0] = '{1'b1, 32'h2000A020, 32'h00001388, 0,     32'h00000000, 1'b0, 1'b0, 3};
        vec[1] = '{1'b1, 32'h20008004, 32'h00123456, 0,     32'h00000000, 1'b0, 1'b0, 3};
        vec[2] = '{1'b0, 32'h20008004, 32'h0,        2,     32'h00123456, 1'b0, 1'b0, 5};
        vec[3] = '{1'b1, 32'h2000E080, 32'hDEADBEEF, 0,     32'h00000000, 1'b1, 1'b0, 4};
        vec[4] = '{1'b0, 32'h2000E080, 32'h0,        1,     32'h00000000, 1'b1, 1'b0, 5};
        vec[5] = '{1'b0, 32'h2000A020, 32'h0,        TMO-1, 32'h00001388, 1'b0, 1'b0, 10};
        vec[6] = '{1'b0, 32'h20001000, 32'h0,        0,     32'h85A54A5A, 1'b0, 1'b0, 3};
        vec[7] = '{1'b1, 32'h20001000, 32'hCAFEF00D, TMO,   32'h00000000, 1'b0, 1'b1, 10};
        vec[8] = '{1'b0, 32'h20001000, 32'h0,        0,     32'h85A54A5A, 1'b0, 1'b0, 3};

        // Reset values.
        repeat (3) @(negedge clk100m);
        check("rst_htrans", 32'(htrans), 32'd0);
        check("rst_haddr", haddr, 32'd0);
        check("rst_hwrite", 32'(hwrite), 32'd0);
        check("rst_hwdata", hwdata, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hsize", 32'(hsize), 32'd2);
        check("rst_hburst", 32'(hburst), 32'd0);
        rst_n = 1'b1;
        @(negedge clk100m);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            base = rsp_cnt;
            push(vec[i].w, vec[i].a, vec[i].d, vec[i].waits);
            wait_rsp(base + 1, $sformatf("vec%0d_rsp", i));
            check($sformatf("vec%0d_nonseq_lat", i), 32'(acc_cyc[$] - push_cyc), 32'd1);
            check($sformatf("vec%0d_lat", i), 32'(last_rsp_cyc - push_cyc), 32'(vec[i].lat));
            check($sformatf("vec%0d_rdata", i), last_rdata, vec[i].rdata);
            check($sformatf("vec%0d_err", i), 32'(last_err), 32'(vec[i].err));
            check($sformatf("vec%0d_tmo", i), 32'(last_tmo), 32'(vec[i].tmo));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // Fill the FIFO while the slave holds hready low, then drain back-to-back.
        idle_hold = 1'b1;
        base = rsp_cnt;
        acc_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            push(i[0], 32'h20002000 + 32'(i * 4), 32'h11110000 + 32'(i), 0);
            check($sformatf("fill%0d_cmd_ready", i), 32'(cmd_ready), (i == 3) ? 32'd0 : 32'd1);
        end
        check("fill_busy", 32'(busy), 32'd1);
        @(negedge clk100m);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20003000; cmd_wdata = 32'hBAD0BAD0;
        @(posedge clk100m);
        #1;
        cmd_valid = 1'b0;
        check("full_push_ignored", 32'(cmd_ready), 32'd0);
        idle_hold = 1'b0;
        wait_rsp(base + 4, "fill_rsp");
        check("fill_accepts", 32'(acc_cyc.size()), 32'd4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            check($sformatf("fill_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        check("fill_busy_done", 32'(busy), 32'd0);

        // Error followed by a queued command.
        base = rsp_cnt;
        push(1'b1, 32'h2000E080, 32'h0000ABCD, 0);
        push(1'b0, 32'h2000A020, 32'h0, 0);
        wait_rsp(base + 2, "err_next_rsp");
        check("err_next_rdata", last_rdata, 32'h00001388);
        check("err_next_err", 32'(last_err), 32'd0);

        // Watchdog: slave stalls forever, next command must wait for hready.
        base = rsp_cnt;
        push(1'b0, 32'h20004000, 32'h0, STALL);
        wait_rsp(base + 1, "tmo_rsp");
        check("tmo_lat", 32'(last_rsp_cyc - push_cyc), 32'd10);
        check("tmo_flag", 32'(last_tmo), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);
        push(1'b1, 32'h20004004, 32'h55AA55AA, 0);
        repeat (6) begin
            @(negedge clk100m);
            check("tmo_no_nonseq", 32'(htrans), 32'd0);
        end
        check("tmo_busy_queued", 32'(busy), 32'd1);
        @(posedge clk100m);
        #1;
        release_stall = 1'b1;
        wait_rsp(base + 2, "tmo_after_rsp");
        check("tmo_after_flag", 32'(last_tmo), 32'd0);

        // Reset in the middle of a data phase.
        push(1'b0, 32'h20005000, 32'h0, 5);
        push(1'b0, 32'h20005004, 32'h0, 0);
        @(negedge clk100m);
        @(negedge clk100m);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        bus_q.delete();
        check("mid_rst_htrans", 32'(htrans), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk100m);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk100m);
            check("post_rst_idle", 32'(htrans), 32'd0);
        end
        check("post_rst_busy", 32'(busy), 32'd0);
        base = rsp_cnt;
        push(1'b1, 32'h20005008, 32'h00000077, 0);
        push(1'b0, 32'h20005008, 32'h0, 1);
        wait_rsp(base + 2, "post_rst_rsp");
        check("post_rst_rdata", last_rdata, 32'h00000077);

        // Random traffic against the reference model.
        base = rsp_cnt;
        for (int i = 0; i < 60; i++) begin
            logic        w;
            logic [31:0] a;
            int          waits;
            w = 1'($urandom_range(0, 1));
            a = (($urandom_range(0, 4) == 0) ? 32'h2000E000 : 32'h20006000) + 32'($urandom_range(0, 7) * 4);
            waits = ($urandom_range(0, 9) == 0) ? TMO + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk100m);
            push(w, a, $urandom(), waits);
        end
        wait_rsp(base + 60, "rand_rsp");
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (12) @(negedge clk100m);
        check("rand_busy_done", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
